or32_bus_arbiter: RTL and testbench

OR32_BUS_ARBITER -- requirements
Module: or32_bus_arbiter

---
 rtl/or32_bus_pkg.sv | 19 +
 rtl/or32_bus_req_slot.sv | 51 +++++
 rtl/or32_bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_or32_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/or32_bus_pkg.sv
// Shared types and constants for the OR32 two-master bus arbiter.
// Defines the FSM state encoding, the bus widths and the captured request record.
// Contains no logic; latency and backpressure are properties of the modules that import it.
package or32_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_WE_W   = 4;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_WAIT = 1'b1;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_ADDR_W-1:0] dat_w;
        logic [BUS_WE_W-1:0]   we;
    } bus_req_t;

endpackage

// File: rtl/or32_bus_req_slot.sv
// Single-entry request holder for one master: a capture register plus a pending flag.
// Latency: a strobe is captured on the edge it is sampled, so pending is visible the next cycle.
// Backpressure: strobes that arrive while the slot is full are dropped; a slot emptied by i_clr accepts a strobe on that same edge.
module or32_bus_req_slot
    import or32_bus_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stb,
    input  logic [BUS_ADDR_W-1:0] i_addr,
    input  logic [BUS_ADDR_W-1:0] i_dat_w,
    input  logic [BUS_WE_W-1:0]   i_we,
    input  logic                  i_clr,
    output logic                  o_pending,
    output bus_req_t              o_req
);

    logic     pending_q, pending_d;
    bus_req_t req_q, req_d;
    logic     capture;

    // Freeing and refilling on one edge lets a master re-request back to back on its ack.
    assign capture = i_stb && (!pending_q || i_clr);

    always_comb begin
        pending_d = pending_q;
        req_d     = req_q;
        if (capture) begin
            pending_d   = 1'b1;
            req_d.addr  = i_addr;
            req_d.dat_w = i_dat_w;
            req_d.we    = i_we;
        end else if (i_clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
            req_q     <= '0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
        end
    end

    assign o_pending = pending_q;
    assign o_req     = req_q;

endmodule

// File: rtl/or32_bus_arbiter.sv
// Two-master to one-slave arbiter (fixed priority, or round-robin with OR32_ARB_ROUND_ROBIN_EN).
// Latency: master strobe at edge N -> slave strobe sampled high at edge N+2; slave ack -> master ack the next cycle.
// Backpressure: one outstanding slave transaction; each master holds one request, extra strobes are dropped.
module or32_bus_arbiter
    import or32_bus_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic                i_clk,
    input  logic                i_rst_n,

    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [ADDR_W-1:0]   i_m0_dat_w,
    input  logic [BUS_WE_W-1:0] i_m0_we,
    input  logic                i_m0_stb,
    output logic [ADDR_W-1:0]   o_m0_dat_r,
    output logic                o_m0_ack,

    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [ADDR_W-1:0]   i_m1_dat_w,
    input  logic [BUS_WE_W-1:0] i_m1_we,
    input  logic                i_m1_stb,
    output logic [ADDR_W-1:0]   o_m1_dat_r,
    output logic                o_m1_ack,

    output logic [ADDR_W-1:0]   o_s_addr,
    output logic [ADDR_W-1:0]   o_s_dat_w,
    output logic [BUS_WE_W-1:0] o_s_we,
    output logic                o_s_stb,
    input  logic [ADDR_W-1:0]   i_s_dat_r,
    input  logic                i_s_ack,

    output logic                o_busy,
    output logic                o_grant
);

    arb_state_t            state_q, state_d;
    logic                  grant_q, grant_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [ADDR_W-1:0]     s_dat_w_q, s_dat_w_d;
    logic [BUS_WE_W-1:0]   s_we_q, s_we_d;
    logic                  s_stb_q, s_stb_d;
    logic                  busy_q, busy_d;
    logic [ADDR_W-1:0]     m0_dat_r_q, m0_dat_r_d;
    logic [ADDR_W-1:0]     m1_dat_r_q, m1_dat_r_d;
    logic                  m0_ack_q, m0_ack_d;
    logic                  m1_ack_q, m1_ack_d;

    logic                  pend0, pend1;
    bus_req_t              req0, req1, win_req;
    logic                  ack_fire, issue, win, clr0, clr1;

    assign ack_fire = (state_q == ST_WAIT) && i_s_ack;
    assign issue    = (state_q == ST_IDLE) && (pend0 || pend1);
    assign clr0     = ack_fire && !grant_q;
    assign clr1     = ack_fire && grant_q;

    or32_bus_req_slot u_slot0 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_stb     (i_m0_stb),
        .i_addr    (i_m0_addr),
        .i_dat_w   (i_m0_dat_w),
        .i_we      (i_m0_we),
        .i_clr     (clr0),
        .o_pending (pend0),
        .o_req     (req0)
    );

    or32_bus_req_slot u_slot1 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_stb     (i_m1_stb),
        .i_addr    (i_m1_addr),
        .i_dat_w   (i_m1_dat_w),
        .i_we      (i_m1_we),
        .i_clr     (clr1),
        .o_pending (pend1),
        .o_req     (req1)
    );

`ifdef OR32_ARB_ROUND_ROBIN_EN
    // grant_q only changes at issue, so it doubles as the last-granted master.
    assign win = (pend0 && pend1) ? ~grant_q : pend1;
`else
    assign win = ~pend0;
`endif

    assign win_req = win ? req1 : req0;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_addr_d   = s_addr_q;
        s_dat_w_d  = s_dat_w_q;
        s_we_d     = s_we_q;
        s_stb_d    = 1'b0;
        busy_d     = busy_q;
        m0_dat_r_d = m0_dat_r_q;
        m1_dat_r_d = m1_dat_r_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;

        if (issue) begin
            state_d   = ST_WAIT;
            grant_d   = win;
            s_addr_d  = win_req.addr;
            s_dat_w_d = win_req.dat_w;
            s_we_d    = win_req.we;
            s_stb_d   = 1'b1;
            busy_d    = 1'b1;
        end

        // An ack with no transaction outstanding is stale and falls through untouched.
        if (ack_fire) begin
            state_d = ST_IDLE;
            s_we_d  = '0;
            busy_d  = 1'b0;
            if (grant_q) begin
                m1_dat_r_d = i_s_dat_r;
                m1_ack_d   = 1'b1;
            end else begin
                m0_dat_r_d = i_s_dat_r;
                m0_ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b1;
            s_addr_q   <= '0;
            s_dat_w_q  <= '0;
            s_we_q     <= '0;
            s_stb_q    <= 1'b0;
            busy_q     <= 1'b0;
            m0_dat_r_q <= '0;
            m1_dat_r_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_addr_q   <= s_addr_d;
            s_dat_w_q  <= s_dat_w_d;
            s_we_q     <= s_we_d;
            s_stb_q    <= s_stb_d;
            busy_q     <= busy_d;
            m0_dat_r_q <= m0_dat_r_d;
            m1_dat_r_q <= m1_dat_r_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
        end
    end

    assign o_s_addr   = s_addr_q;
    assign o_s_dat_w  = s_dat_w_q;
    assign o_s_we     = s_we_q;
    assign o_s_stb    = s_stb_q;
    assign o_busy     = busy_q;
    assign o_grant    = grant_q;
    assign o_m0_dat_r = m0_dat_r_q;
    assign o_m1_dat_r = m1_dat_r_q;
    assign o_m0_ack   = m0_ack_q;
    assign o_m1_ack   = m1_ack_q;

endmodule

// File: tb/tb_or32_bus_arbiter.sv
// Directed bench for or32_bus_arbiter; expectations follow the build's arbitration mode.
module tb_or32_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_m0_addr = '0, i_m0_dat_w = '0;
    logic [3:0]  i_m0_we = '0;
    logic        i_m0_stb = 1'b0;
    logic [31:0] o_m0_dat_r;
    logic        o_m0_ack;
    logic [31:0] i_m1_addr = '0, i_m1_dat_w = '0;
    logic [3:0]  i_m1_we = '0;
    logic        i_m1_stb = 1'b0;
    logic [31:0] o_m1_dat_r;
    logic        o_m1_ack;
    logic [31:0] o_s_addr, o_s_dat_w;
    logic [3:0]  o_s_we;
    logic        o_s_stb;
    logic [31:0] i_s_dat_r = '0;
    logic        i_s_ack = 1'b0;
    logic        o_busy, o_grant;

    int tests = 0;
    int fails = 0;
    int stb_cnt = 0;
    int ack0_cnt = 0;

    always #5 i_clk = ~i_clk;

    or32_bus_arbiter #(.ADDR_W(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_addr(i_m0_addr), .i_m0_dat_w(i_m0_dat_w), .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb),
        .o_m0_dat_r(o_m0_dat_r), .o_m0_ack(o_m0_ack),
        .i_m1_addr(i_m1_addr), .i_m1_dat_w(i_m1_dat_w), .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb),
        .o_m1_dat_r(o_m1_dat_r), .o_m1_ack(o_m1_ack),
        .o_s_addr(o_s_addr), .o_s_dat_w(o_s_dat_w), .o_s_we(o_s_we), .o_s_stb(o_s_stb),
        .i_s_dat_r(i_s_dat_r), .i_s_ack(i_s_ack),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    always @(negedge i_clk) begin
        if (o_s_stb)  stb_cnt++;
        if (o_m0_ack) ack0_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int s0, a0, n_iter;
        logic exp_g, prev_g, rr_mode;
`ifdef OR32_ARB_ROUND_ROBIN_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif

        // Reset state
        tick; tick;
        chk("rst_grant", 32'(o_grant), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_s_stb", 32'(o_s_stb), 32'd0);
        chk("rst_s_we", 32'(o_s_we), 32'd0);
        chk("rst_m0_ack", 32'(o_m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(o_m1_ack), 32'd0);
        chk("rst_s_addr", o_s_addr, 32'h0);
        chk("rst_m0_dat_r", o_m0_dat_r, 32'h0);
        i_rst_n = 1'b1;
        tick;

        // Single read from m0, slave acks three cycles after the strobe
        i_m0_addr = 32'h100; i_m0_stb = 1'b1;
        tick;
        i_m0_stb = 1'b0;
        chk("rd_no_early_stb", 32'(o_s_stb), 32'd0);
        tick;
        chk("rd_s_stb", 32'(o_s_stb), 32'd1);
        chk("rd_s_addr", o_s_addr, 32'h100);
        chk("rd_grant", 32'(o_grant), 32'd0);
        chk("rd_busy", 32'(o_busy), 32'd1);
        tick;
        chk("rd_stb_one_cycle", 32'(o_s_stb), 32'd0);
        chk("rd_busy_wait", 32'(o_busy), 32'd1);
        tick;
        i_s_ack = 1'b1; i_s_dat_r = 32'hDEADBEEF;
        tick;
        i_s_ack = 1'b0;
        chk("rd_m0_ack", 32'(o_m0_ack), 32'd1);
        chk("rd_m0_dat_r", o_m0_dat_r, 32'hDEADBEEF);
        chk("rd_m1_ack", 32'(o_m1_ack), 32'd0);
        chk("rd_busy_done", 32'(o_busy), 32'd0);
        tick;
        chk("rd_ack_pulse", 32'(o_m0_ack), 32'd0);
        chk("rd_dat_hold", o_m0_dat_r, 32'hDEADBEEF);

        // Byte write from m1
        i_m1_addr = 32'h200; i_m1_dat_w = 32'h000000AA; i_m1_we = 4'h1; i_m1_stb = 1'b1;
        tick;
        i_m1_stb = 1'b0;
        tick;
        chk("wr_s_stb", 32'(o_s_stb), 32'd1);
        chk("wr_grant", 32'(o_grant), 32'd1);
        chk("wr_s_dat_w", o_s_dat_w, 32'h000000AA);
        chk("wr_s_we_issue", 32'(o_s_we), 32'h1);
        tick;
        chk("wr_s_we_hold1", 32'(o_s_we), 32'h1);
        tick;
        chk("wr_s_we_hold2", 32'(o_s_we), 32'h1);
        i_s_ack = 1'b1; i_s_dat_r = 32'h12345678;
        tick;
        i_s_ack = 1'b0;
        chk("wr_m1_ack", 32'(o_m1_ack), 32'd1);
        chk("wr_m1_dat_r", o_m1_dat_r, 32'h12345678);
        chk("wr_s_we_clear", 32'(o_s_we), 32'h0);
        chk("wr_m0_ack_quiet", 32'(o_m0_ack), 32'd0);
        chk("wr_m0_dat_keep", o_m0_dat_r, 32'hDEADBEEF);
        tick;

        // Stale ack while idle
        i_s_ack = 1'b1; i_s_dat_r = 32'h0BADF00D;
        tick;
        i_s_ack = 1'b0;
        chk("stale_m0_ack", 32'(o_m0_ack), 32'd0);
        chk("stale_m1_ack", 32'(o_m1_ack), 32'd0);
        chk("stale_m1_dat", o_m1_dat_r, 32'h12345678);
        tick;

        // Duplicate strobe from m0 before its ack
        s0 = stb_cnt; a0 = ack0_cnt;
        i_m1_we = 4'h0; i_m0_addr = 32'h40; i_m0_stb = 1'b1;
        tick;
        i_m0_addr = 32'h80;
        tick;
        i_m0_stb = 1'b0;
        chk("dup_s_addr", o_s_addr, 32'h40);
        tick;
        i_s_ack = 1'b1; i_s_dat_r = 32'h55;
        tick;
        i_s_ack = 1'b0;
        chk("dup_m0_dat_r", o_m0_dat_r, 32'h55);
        tick; tick; tick;
        chk("dup_busy", 32'(o_busy), 32'd0);
        chk("dup_stb_count", 32'(stb_cnt - s0), 32'd1);
        chk("dup_ack_count", 32'(ack0_cnt - a0), 32'd1);

        // Simultaneous requests from reset: m0 then m1, twice
        i_rst_n = 1'b0;
        tick;
        i_rst_n = 1'b1;
        tick;
        for (int r = 0; r < 2; r++) begin
            i_m0_addr = 32'h10; i_m1_addr = 32'h20; i_m0_stb = 1'b1; i_m1_stb = 1'b1;
            tick;
            i_m0_stb = 1'b0; i_m1_addr = 32'h99;
            tick;
            i_m1_stb = 1'b0;
            chk("pair_first_grant", 32'(o_grant), 32'd0);
            chk("pair_first_addr", o_s_addr, 32'h10);
            i_s_ack = 1'b1; i_s_dat_r = 32'hA0 + 32'(r);
            tick;
            i_s_ack = 1'b0;
            chk("pair_m0_ack", 32'(o_m0_ack), 32'd1);
            chk("pair_m0_dat", o_m0_dat_r, 32'hA0 + 32'(r));
            tick;
            chk("pair_second_stb", 32'(o_s_stb), 32'd1);
            chk("pair_second_grant", 32'(o_grant), 32'd1);
            chk("pair_second_addr", o_s_addr, 32'h20);
            i_s_ack = 1'b1; i_s_dat_r = 32'hA8 + 32'(r);
            tick;
            i_s_ack = 1'b0;
            chk("pair_m1_ack", 32'(o_m1_ack), 32'd1);
            chk("pair_m1_dat", o_m1_dat_r, 32'hA8 + 32'(r));
            tick;
        end

        // m0 re-requests on every ack while m1 waits
        i_m0_addr = 32'h10; i_m1_addr = 32'h20; i_m0_stb = 1'b1; i_m1_stb = 1'b1;
        tick;
        i_m0_stb = 1'b0; i_m1_stb = 1'b0;
        tick;
        chk("starve_first_grant", 32'(o_grant), 32'd0);
        prev_g = 1'b0;
        n_iter = rr_mode ? 1 : 3;
        exp_g = rr_mode;
        for (int i = 0; i < n_iter; i++) begin
            i_s_ack = 1'b1; i_s_dat_r = 32'hB0 + 32'(i); i_m0_stb = 1'b1;
            tick;
            i_s_ack = 1'b0; i_m0_stb = 1'b0;
            chk("starve_m0_ack", 32'(o_m0_ack), 32'(!prev_g));
            chk("starve_m1_ack", 32'(o_m1_ack), 32'(prev_g));
            tick;
            chk("starve_issue", 32'(o_s_stb), 32'd1);
            chk("starve_grant", 32'(o_grant), 32'(exp_g));
            prev_g = exp_g;
        end
        i_s_ack = 1'b1; i_s_dat_r = 32'hC0;
        tick;
        i_s_ack = 1'b0;
        tick;
        chk("drain_issue", 32'(o_s_stb), 32'd1);
        chk("drain_grant", 32'(o_grant), 32'(!rr_mode));
        i_s_ack = 1'b1; i_s_dat_r = 32'hC1;
        tick;
        i_s_ack = 1'b0;
        tick;
        chk("drain_idle_busy", 32'(o_busy), 32'd0);
        chk("drain_idle_stb", 32'(o_s_stb), 32'd0);

        // Reset in the middle of a write transaction
        i_m0_addr = 32'h300; i_m0_dat_w = 32'h77; i_m0_we = 4'h3; i_m0_stb = 1'b1;
        tick;
        i_m0_stb = 1'b0;
        tick;
        chk("mid_s_we_pre", 32'(o_s_we), 32'h3);
        tick;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(o_busy), 32'd0);
        chk("mid_grant", 32'(o_grant), 32'd1);
        chk("mid_s_we", 32'(o_s_we), 32'h0);
        chk("mid_s_addr", o_s_addr, 32'h0);
        chk("mid_m0_dat_r", o_m0_dat_r, 32'h0);
        chk("mid_m1_dat_r", o_m1_dat_r, 32'h0);
        tick; tick;
        i_rst_n = 1'b1;
        i_m0_we = 4'h0;
        tick;
        i_s_ack = 1'b1; i_s_dat_r = 32'h999;
        tick;
        i_s_ack = 1'b0;
        chk("late_m0_ack", 32'(o_m0_ack), 32'd0);
        chk("late_m1_ack", 32'(o_m1_ack), 32'd0);
        chk("late_m0_dat", o_m0_dat_r, 32'h0);
        i_m0_addr = 32'h400; i_m0_stb = 1'b1;
        tick;
        i_m0_stb = 1'b0;
        tick;
        chk("post_rst_stb", 32'(o_s_stb), 32'd1);
        chk("post_rst_addr", o_s_addr, 32'h400);
        i_s_ack = 1'b1; i_s_dat_r = 32'hCAFEF00D;
        tick;
        i_s_ack = 1'b0;
        chk("post_rst_ack", 32'(o_m0_ack), 32'd1);
        chk("post_rst_dat", o_m0_dat_r, 32'hCAFEF00D);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
